// File: rtl/keypad_event_filter.sv
// Turns raw keypad levels into debounced, single-shot connect4 column events.
// Each event is held in a one-entry valid/ready register until it is accepted.
module keypad_event_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  input  logic       pop_mode,
  input  logic       flush,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [2:0] ev_col,
  output logic       ev_pop,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    WAIT_REL = 2'd2,
    DB_REL   = 2'd3
  } state_e;

  logic [1:0] pressed_sync_q;
  logic [3:0] code_s1_q, code_s2_q;
  logic [1:0] pop_sync_q;

  logic       pressed_s;
  logic [3:0] code_s;
  logic       pop_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_lat_q, code_lat_d;
  logic             qualify;
  logic             load;

  logic       ev_valid_q, ev_valid_d;
  logic [2:0] ev_col_q, ev_col_d;
  logic       ev_pop_q, ev_pop_d;
  logic       overflow_q, overflow_d;

  // Two-flop synchronisers for the asynchronous keypad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_sync_q <= '0;
      code_s1_q      <= '0;
      code_s2_q      <= '0;
      pop_sync_q     <= '0;
    end else begin
      pressed_sync_q <= {pressed_sync_q[0], key_pressed};
      code_s1_q      <= key_code;
      code_s2_q      <= code_s1_q;
      pop_sync_q     <= {pop_sync_q[0], pop_mode};
    end
  end

  assign pressed_s = pressed_sync_q[1];
  assign code_s    = code_s2_q;
  assign pop_s     = pop_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_lat_q <= '0;
      ev_valid_q <= 1'b0;
      ev_col_q   <= '0;
      ev_pop_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_lat_q <= code_lat_d;
      ev_valid_q <= ev_valid_d;
      ev_col_q   <= ev_col_d;
      ev_pop_q   <= ev_pop_d;
      overflow_q <= overflow_d;
    end
  end

  // Press/release debounce; a code change mid-press restarts the debounce
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_lat_d = code_lat_q;
    qualify    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d    = DB_PRESS;
          cnt_d      = '0;
          code_lat_d = code_s;
        end
      end
      DB_PRESS: begin
        if (!pressed_s || (code_s != code_lat_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          qualify = 1'b1;
          state_d = WAIT_REL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!pressed_s) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end
      end
      DB_REL: begin
        if (pressed_s) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only column keys 1..7 become events
  assign load = qualify && !code_lat_q[3] && (code_lat_q != 4'd0);

  // One-entry event register; flush wins over load and accept
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_col_d   = ev_col_q;
    ev_pop_d   = ev_pop_q;
    overflow_d = 1'b0;
    if (flush) begin
      ev_valid_d = 1'b0;
    end else if (load) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d = 1'b1;
        ev_col_d   = 3'(code_lat_q - 4'd1);
        ev_pop_d   = pop_s;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (ev_ready) begin
      ev_valid_d = 1'b0;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_col    = ev_col_q;
  assign ev_pop    = ev_pop_q;
  assign overflow  = overflow_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_keypad_event_filter.sv
// Bench for keypad_event_filter: a run-length debounce model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_keypad_event_filter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_pressed;
  logic [3:0] key_code;
  logic       pop_mode;
  logic       flush;
  logic       ev_ready;
  logic       ev_valid;
  logic [2:0] ev_col;
  logic       ev_pop;
  logic       overflow;
  logic [1:0] fsm_state;

  int n_chk  = 0;
  int n_pass = 0;

  keypad_event_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_pressed(key_pressed),
    .key_code   (key_code),
    .pop_mode   (pop_mode),
    .flush      (flush),
    .ev_ready   (ev_ready),
    .ev_valid   (ev_valid),
    .ev_col     (ev_col),
    .ev_pop     (ev_pop),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // Model: inputs become visible two edges late; a press counts once it has been
  // seen for D+1 consecutive edges while armed, and re-arms after D+1 low edges.
  bit         p_d1, p_d2, o_d1, o_d2;
  logic [3:0] c_d1, c_d2;
  bit         armed;
  int         hi_run, lo_run;
  logic [3:0] lat;
  bit         m_vld, m_pop, m_ov;
  logic [2:0] m_col;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit         vp, vo, qual;
    logic [3:0] vc;
    if (!rst_n) begin
      p_d1 = 0; p_d2 = 0; o_d1 = 0; o_d2 = 0; c_d1 = '0; c_d2 = '0;
      armed = 1; hi_run = 0; lo_run = 0; lat = '0;
      m_vld = 0; m_col = '0; m_pop = 0; m_ov = 0;
    end else begin
      vp = p_d2; vc = c_d2; vo = o_d2;
      p_d2 = p_d1; p_d1 = key_pressed;
      c_d2 = c_d1; c_d1 = key_code;
      o_d2 = o_d1; o_d1 = pop_mode;
      qual = 0;
      if (armed) begin
        if (!vp) hi_run = 0;
        else if (hi_run > 0 && vc != lat) hi_run = 0;
        else begin
          hi_run++;
          if (hi_run == 1) lat = vc;
          if (hi_run == D + 1) begin qual = 1; armed = 0; lo_run = 0; end
        end
      end else begin
        if (vp) lo_run = 0;
        else begin
          lo_run++;
          if (lo_run == D + 1) begin armed = 1; hi_run = 0; end
        end
      end
      m_ov = 0;
      if (flush) m_vld = 0;
      else if (qual && lat >= 1 && lat <= 7) begin
        if (!m_vld || ev_ready) begin
          m_vld = 1; m_col = 3'(lat - 4'd1); m_pop = vo;
        end else m_ov = 1;
      end else if (ev_ready) m_vld = 0;
    end
  endtask

  task automatic model_cmp();
    chk("m_ev_valid", int'(ev_valid), int'(m_vld));
    chk("m_overflow", int'(overflow), int'(m_ov));
    if (m_vld) begin
      chk("m_ev_col", int'(ev_col), int'(m_col));
      chk("m_ev_pop", int'(ev_pop), int'(m_pop));
    end
  endtask

  // Every clock edge goes through here so the model never misses a cycle
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      model_cmp();
    end
  endtask

  task automatic run(input int n, output int nev, output int nov);
    nev = 0; nov = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (ev_valid) nev++;
      if (overflow) nov++;
    end
  endtask

  initial begin
    int nev, nov, tev, tov, first;
    logic [3:0] bad [3];
    bad[0] = 4'h0; bad[1] = 4'h8; bad[2] = 4'hF;

    rst_n = 0; key_pressed = 0; key_code = 0; pop_mode = 0; flush = 0; ev_ready = 1;
    step(3);
    chk("rst_valid", int'(ev_valid), 0);
    chk("rst_state", int'(fsm_state), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1;
    step(2);

    // Clean press of key 3
    key_code = 4'd3; pop_mode = 0; key_pressed = 1;
    nev = 0;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (ev_valid) nev++;
      if (e == 3) chk("clean_dbpress", int'(fsm_state), 1);
      if (e == 7) begin
        chk("clean_valid", int'(ev_valid), 1);
        chk("clean_col", int'(ev_col), 2);
        chk("clean_pop", int'(ev_pop), 0);
        chk("clean_waitrel", int'(fsm_state), 2);
      end
      if (e == 8) chk("clean_one_cycle", int'(ev_valid), 0);
    end
    chk("clean_count", nev, 1);
    key_pressed = 0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      if (e == 6) chk("rel_dbrel", int'(fsm_state), 3);
      if (e == 7) chk("rel_idle", int'(fsm_state), 0);
    end
    step(3);

    // Press bounce on key 5
    key_code = 4'd5; key_pressed = 1; step(2);
    key_pressed = 0; step(2);
    key_pressed = 1;
    nev = 0; first = 0;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (ev_valid) begin
        nev++;
        if (first == 0) begin first = e; chk("bounce_col", int'(ev_col), 4); end
      end
    end
    chk("bounce_count", nev, 1);
    chk("bounce_time", first, 7);
    // Short release glitch while held
    key_pressed = 0; step(3);
    key_pressed = 1;
    run(15, nev, nov);
    chk("relglitch_count", nev, 0);
    chk("relglitch_state", int'(fsm_state), 2);
    key_pressed = 0; step(10);
    chk("bounce_idle", int'(fsm_state), 0);

    // Non-column keys
    tev = 0; tov = 0;
    for (int i = 0; i < 3; i++) begin
      key_code = bad[i]; key_pressed = 1;
      run(10, nev, nov); tev += nev; tov += nov;
      chk("invalid_waitrel", int'(fsm_state), 2);
      key_pressed = 0;
      run(10, nev, nov); tev += nev; tov += nov;
    end
    chk("invalid_events", tev, 0);
    chk("invalid_ovf", tov, 0);

    // Backpressure and overflow
    ev_ready = 0; key_code = 4'd1; pop_mode = 1; key_pressed = 1;
    step(10);
    chk("bp_valid", int'(ev_valid), 1);
    chk("bp_col", int'(ev_col), 0);
    chk("bp_pop", int'(ev_pop), 1);
    key_pressed = 0; step(10);
    key_code = 4'd7; pop_mode = 0; key_pressed = 1;
    run(10, nev, nov);
    chk("bp_ovf_pulses", nov, 1);
    chk("bp_col_held", int'(ev_col), 0);
    chk("bp_still_valid", int'(ev_valid), 1);
    key_pressed = 0; step(10);
    ev_ready = 1; step(1);
    chk("bp_accepted", int'(ev_valid), 0);

    // Accept and load on the same edge
    ev_ready = 0; key_code = 4'd2; key_pressed = 1; step(10);
    key_pressed = 0; step(10);
    chk("same_pending_col", int'(ev_col), 1);
    key_code = 4'd6; key_pressed = 1; step(6);
    ev_ready = 1; step(1);
    chk("same_valid", int'(ev_valid), 1);
    chk("same_col", int'(ev_col), 5);
    chk("same_ovf", int'(overflow), 0);
    step(1);
    chk("same_drained", int'(ev_valid), 0);
    key_pressed = 0; step(10);

    // Reset mid-debounce with key held
    key_code = 4'd4; key_pressed = 1; step(5);
    chk("rstmid_dbpress", int'(fsm_state), 1);
    rst_n = 0; #1;
    chk("rstmid_state", int'(fsm_state), 0);
    chk("rstmid_valid", int'(ev_valid), 0);
    chk("rstmid_ovf", int'(overflow), 0);
    chk("rstmid_col", int'(ev_col), 0);
    chk("rstmid_pop", int'(ev_pop), 0);
    step(2);
    rst_n = 1;
    nev = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (ev_valid) nev++;
      if (e == 7) begin
        chk("rstmid_event", int'(ev_valid), 1);
        chk("rstmid_evcol", int'(ev_col), 3);
      end
    end
    chk("rstmid_count", nev, 1);
    key_pressed = 0; step(10);

    // Flush a pending event while the key stays held
    ev_ready = 0; key_code = 4'd2; key_pressed = 1; step(10);
    chk("flush_pre", int'(ev_valid), 1);
    flush = 1; step(1);
    flush = 0;
    chk("flush_cleared", int'(ev_valid), 0);
    run(15, nev, nov);
    chk("flush_no_new", nev, 0);
    key_pressed = 0; step(10);
    ev_ready = 1; step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_event_filter.md
# keypad_event_filter

Converts the keypad decoder's raw key levels into clean, single-shot move events for the connect4 game logic. It sits between the keypad decoder and connect4.

- Debounces press and release.
- Accepts only column keys 1–7.
- Tags each event with the pop/drop mode.
- Holds the event in a one-entry valid/ready register until the game logic accepts it.

## Interface

- DEBOUNCE_CYCLES, 1000000, cycles an input must stay stable to qualify a press or release (10 ms at 100 MHz). Legal range is ≥2.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- clk  in  1  system clock (100 MHz). Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_pressed  in  1  level, high while any keypad key is held. Asynchronous to clk.
- key_code  in  4  decoded key value 0x0–0xF. Asynchronous to clk.
- pop_mode  in  1  level, high selects a pop move instead of a drop. Asynchronous to clk.
- flush  in  1  synchronous clear of any pending event (game reset).
- ev_ready  in  1  game logic can accept an event.
- ev_valid  out  1  event pending.
- ev_col  out  3  column 0–6.
- ev_pop  out  1  1 = pop, 0 = drop.
- overflow  out  1  one-cycle pulse when a qualified event is dropped.
- fsm_state  out  2  current state, for debug.

## Operation

- Synchronisation: key_pressed, key_code and pop_mode each pass through a 2-flop synchroniser. Sync registers reset to 0.
- FSM states:
  - IDLE = 0
  - DB_PRESS = 1
  - WAIT_REL = 2
  - DB_REL = 3
- IDLE:
  - Synced pressed = 1 → DB_PRESS.
  - On that transition: cnt ← 0, code_lat ← synced key_code.
- DB_PRESS:
  - Synced pressed = 0, or synced key_code ≠ code_lat → IDLE (glitch rejected, no event).
  - Otherwise, if cnt = DEBOUNCE_CYCLES−1 → qualify the press and go to WAIT_REL.
  - Otherwise cnt ← cnt+1.
- Qualify:
  - code_lat in 1–7: event = {col = code_lat−1, pop = synced pop_mode}.
  - code_lat 0 or 8–F: no event and no overflow. The FSM still goes to WAIT_REL.
- WAIT_REL:
  - Synced pressed = 0 → DB_REL, cnt ← 0.
  - Changes of key_code while held are ignored (no rollover events).
- DB_REL:
  - Synced pressed = 1 → WAIT_REL.
  - Otherwise, if cnt = DEBOUNCE_CYCLES−1 → IDLE.
  - Otherwise cnt ← cnt+1.
- Event register:
  - Load: ev_valid ← 1, ev_col and ev_pop ← event.
  - Accept: ev_valid & ev_ready at a clk edge; ev_valid ← 0 on that edge.
  - Load while ev_valid = 1 and not being accepted: the new event is dropped, the held event is unchanged, and overflow pulses for 1 cycle.
  - Accept and load on the same edge: the new event loads, ev_valid stays 1, no overflow.
  - ev_col and ev_pop are stable while ev_valid = 1.
- flush:
  - Clears ev_valid next edge and beats a simultaneous load or accept.
  - Does not change FSM state or the counter, so a key held through flush produces no new event until it is released.
- Reset values: every output is 0 and the FSM is in IDLE.
  - rst_n low mid-debounce aborts immediately; no event is generated after release of reset unless a fresh press is debounced.

## Timing

- Press latency:
  - Edges counted from the first clk edge sampling key_pressed = 1 (key_code/pop_mode stable).
  - Edge 2: synced pressed = 1.
  - Edge 3: DB_PRESS, cnt = 0.
  - Edge DEBOUNCE_CYCLES+3: ev_valid = 1.
- Release latency: the FSM reaches IDLE DEBOUNCE_CYCLES+3 edges after the first edge sampling key_pressed = 0.
- Press bounce: any pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no event.
- Release bounce: any low pulse shorter than DEBOUNCE_CYCLES cycles produces no second event.
- Throughput: at most one event per press-release cycle, which takes at least 2·DEBOUNCE_CYCLES+6 cycles.
- ev_ready: may be held high permanently; each event is then valid for exactly 1 cycle.
- Synchroniser source: pop_mode is taken from the synchronised value on the qualify edge, not at press start.

## Test plan

Benches run with DEBOUNCE_CYCLES = 4 and ev_ready = 1 unless stated.

- Clean press: hold key_code = 3, pop_mode = 0, key_pressed = 1 for 20 cycles → ev_valid pulses once for 1 cycle at edge 7 with ev_col = 2, ev_pop = 0; no further event until release plus 7 cycles.
- Bounce:
  - key_pressed toggles 1,0,1 every 2 cycles with key_code = 5, then stays high → exactly one event, ev_col = 4, timed from the last rising edge.
  - A 3-cycle release glitch mid-hold → no second event.
- Invalid keys: key_code = 0, then 8, then 0xF, each pressed and released cleanly → ev_valid never asserts and overflow stays 0.
- Backpressure:
  - ev_ready = 0; press key 1 (pop_mode = 1) → ev_valid = 1, ev_col = 0, ev_pop = 1, held.
  - Release, then press key 7 → overflow pulses once and ev_col stays 0.
  - Raise ev_ready → accepted; ev_valid = 0 next edge.
- Same-edge accept and load: ev_ready goes high on the exact edge a new key-6 event qualifies while the old one is pending → ev_valid stays 1, ev_col = 5, overflow = 0.
- Reset and flush:
  - rst_n low at DB_PRESS cnt = 2 → all outputs 0 and fsm_state = 0 immediately; after rst_n rises with the key still held, the event arrives DEBOUNCE_CYCLES+3 edges later.
  - flush with ev_valid = 1 → ev_valid = 0 next edge, and no new event while the key is still held.
